msrv32_ahb_dmem_master: RTL
===========================

// Module: msrv32_ahb_dmem_master
// PURPOSE
//  AHB-Lite data-memory master directly downstream of the store unit; also serves load requests.
//  Turns the store unit's dmaddr/dmdata/dmwr_mask/dmwr_req (or a load request) into one AHB-Lite transfer.
//  Runs the transfer through its address and data phases, honours HREADY wait states and two-cycle HRESP errors.
//  Returns ahb_ready to the store unit/pipeline. Returns captured load data to the load unit.
// PARAMETERS
//  ADDR_W      32  bus address width
//  CHK_ALIGN   1   1: misaligned/illegal requests flagged and dropped; 0: issued as given
// PORTS
//  ms_riscv32_mp_clk_in   in   1   clock, rising edge
//  ms_riscv32_mp_rst_in   in   1   reset, asynchronous, active-high
//  dmaddr_in              in   ADDR_W store address (from store unit)
//  dmdata_in              in   32  lane-aligned store data (from store unit)
//  dmwr_mask_in           in   4   byte-lane write mask (from store unit)
//  dmwr_req_in            in   1   store request
//  dmrd_req_in            in   1   load request
//  dmrd_addr_in           in   ADDR_W load address
//  dmrd_size_in           in   2   load size: 00 byte, 01 half, 10 word
//  ahb_hready_in          in   1   HREADY
//  ahb_hresp_in           in   1   HRESP (0 OKAY, 1 ERROR)
//  ahb_hrdata_in          in   32  HRDATA
//  ahb_haddr_out          out  ADDR_W HADDR
//  ahb_htrans_out         out  2   HTRANS (00 IDLE, 10 NONSEQ only)
//  ahb_hwrite_out         out  1   HWRITE
//  ahb_hsize_out          out  3   HSIZE
//  ahb_hwdata_out         out  32  HWDATA
//  ahb_ready_out          out  1   1 = idle, may accept request (feeds store unit ahb_ready_in)
//  dmrdata_out            out  32  captured HRDATA of last completed load
//  dmrdata_valid_out      out  1   1-cycle pulse: dmrdata_out updated
//  bus_err_out            out  1   1-cycle pulse: HRESP ERROR received
//  align_err_out          out  1   1-cycle pulse: request dropped as misaligned/illegal
// BEHAVIOUR
//  Reset (async): state IDLE; htrans 00, all other outputs 0 except ahb_ready_out=1.
//  FSM IDLE -> ADDR -> DATA -> IDLE; DATA -> ERR -> IDLE. Requests sampled only in IDLE.
//  IDLE: ready=1, htrans=00. Store+load in same cycle: store wins, load dropped (core never issues both).
//   Store decode: mask 1111->hsize 010, offset 0. Mask 0011/1100->hsize 001, offset 0/2.
//   Store decode, single one-hot bit->hsize 000, offset = bit index. haddr={addr[ADDR_W-1:2],offset}.
//   Store mask 0000: no transfer. Any other mask with CHK_ALIGN=1: align_err pulse, no transfer.
//   Load: hsize={0,size}. Misaligned (half addr[0]=1, word addr[1:0]!=0) or size 11: align_err, dropped.
//   Valid request: latch addr/size/write/data, next state ADDR.
//  ADDR: htrans=10, haddr/hwrite/hsize from latches, ready=0; hready=1 -> DATA, else hold all outputs.
//  DATA: htrans=00, hwdata=latched data for stores; hready=0 & hresp=0 -> wait.
//   DATA, hready=1 & hresp=0: load -> dmrdata_out<=hrdata, valid pulse next cycle. Go IDLE.
//   DATA, hresp=1 & hready=0: first error cycle -> ERR.
//  ERR: hready=1 -> bus_err pulse next cycle, IDLE; no rdata_valid. Requests are never retried.
//  ahb_hwdata_out holds its value outside DATA. dmrdata_out holds until the next completed load.
//  Zero-wait latency: request cycle N, NONSEQ N+1, data phase N+2, valid/ready=1 at N+3.
//  One transfer outstanding; no back-to-back pipelining of address phases.
//  Reset mid-transfer: immediate IDLE, htrans 00, no pulses; the pending request is lost.
// TESTING
//  sw addr 0x12345678 mask 1111 data AABBCCDD, hready=1 -> NONSEQ haddr ..678 hsize 010, hwdata AABBCCDD @N+2.
//  sb mask 0010 addr 0x12345671 -> haddr 0x12345671 hsize 000; sh mask 1100 addr ..20 -> haddr ..22 hsize 001.
//  lw addr 0x100, hready low 3 cycles in DATA, hrdata 0xDEADBEEF -> ready=0 throughout, then dmrdata 0xDEADBEEF + valid.
//  Data phase: hresp=1/hready=0 then hresp=1/hready=1 -> single bus_err pulse, no valid, ready=1 after.
//  Mask 0101 store; lh addr 0x101 -> align_err pulses, htrans stays 00.
//  Assert reset while in ADDR with hready=0 -> htrans 00, ready=1 same cycle; simultaneous sw+lw -> only write issued.

Source files
------------

// File: rtl/msrv32_ahb_dmem_master.sv
// AHB-Lite data-memory master: turns one store or load request into a single
// NONSEQ transfer, with HREADY wait states and the two-cycle HRESP error handled.
module msrv32_ahb_dmem_master #(
  parameter int ADDR_W    = 32,
  parameter bit CHK_ALIGN = 1'b1
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [ADDR_W-1:0] dmaddr_in,
  input  logic [31:0]       dmdata_in,
  input  logic [3:0]        dmwr_mask_in,
  input  logic              dmwr_req_in,
  input  logic              dmrd_req_in,
  input  logic [ADDR_W-1:0] dmrd_addr_in,
  input  logic [1:0]        dmrd_size_in,
  input  logic              ahb_hready_in,
  input  logic              ahb_hresp_in,
  input  logic [31:0]       ahb_hrdata_in,
  output logic [ADDR_W-1:0] ahb_haddr_out,
  output logic [1:0]        ahb_htrans_out,
  output logic              ahb_hwrite_out,
  output logic [2:0]        ahb_hsize_out,
  output logic [31:0]       ahb_hwdata_out,
  output logic              ahb_ready_out,
  output logic [31:0]       dmrdata_out,
  output logic              dmrdata_valid_out,
  output logic              bus_err_out,
  output logic              align_err_out,
  output logic [1:0]        dbg_state_out
);

  // Handshake: a request is taken only in a cycle where ahb_ready_out=1 (IDLE);
  // the address phase ends on the edge where HREADY=1, the data phase likewise.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_haddr;
  logic [2:0]        r_hsize;
  logic              r_hwrite;
  logic [31:0]       r_wdata;
  logic [31:0]       r_hwdata;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_berr;
  logic              r_aerr;

  logic [2:0]        w_st_hsize;
  logic [1:0]        w_st_off;
  logic              w_st_legal;
  logic              w_ld_legal;
  logic              w_st_go;
  logic              w_st_bad;
  logic              w_ld_go;
  logic              w_ld_bad;
  logic              w_idle;

  // Byte-lane mask to size/offset; illegal masks fall back to the raw address.
  always_comb begin
    w_st_hsize = 3'b010;
    w_st_off   = dmaddr_in[1:0];
    w_st_legal = 1'b1;
    case (dmwr_mask_in)
      4'b1111: begin w_st_hsize = 3'b010; w_st_off = 2'd0; end
      4'b0011: begin w_st_hsize = 3'b001; w_st_off = 2'd0; end
      4'b1100: begin w_st_hsize = 3'b001; w_st_off = 2'd2; end
      4'b0001: begin w_st_hsize = 3'b000; w_st_off = 2'd0; end
      4'b0010: begin w_st_hsize = 3'b000; w_st_off = 2'd1; end
      4'b0100: begin w_st_hsize = 3'b000; w_st_off = 2'd2; end
      4'b1000: begin w_st_hsize = 3'b000; w_st_off = 2'd3; end
      default: w_st_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_ld_legal = 1'b0;
    case (dmrd_size_in)
      2'b00:   w_ld_legal = 1'b1;
      2'b01:   w_ld_legal = ~dmrd_addr_in[0];
      2'b10:   w_ld_legal = (dmrd_addr_in[1:0] == 2'b00);
      default: w_ld_legal = 1'b0;
    endcase
  end

  // Store wins over a simultaneous load; an empty mask is silently ignored.
  assign w_idle   = (r_state == S_IDLE);
  assign w_st_go  = dmwr_req_in && (dmwr_mask_in != 4'b0000) && (w_st_legal || !CHK_ALIGN);
  assign w_st_bad = dmwr_req_in && (dmwr_mask_in != 4'b0000) && !w_st_legal && CHK_ALIGN;
  assign w_ld_go  = !dmwr_req_in && dmrd_req_in && (w_ld_legal || !CHK_ALIGN);
  assign w_ld_bad = !dmwr_req_in && dmrd_req_in && !w_ld_legal && CHK_ALIGN;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_st_go || w_ld_go) w_next = S_ADDR;
      S_ADDR: if (ahb_hready_in) w_next = S_DATA;
      S_DATA: begin
        if (ahb_hresp_in) w_next = ahb_hready_in ? S_IDLE : S_ERR;
        else if (ahb_hready_in) w_next = S_IDLE;
      end
      S_ERR:  if (ahb_hready_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state  <= S_IDLE;
      r_haddr  <= '0;
      r_hsize  <= 3'b000;
      r_hwrite <= 1'b0;
      r_wdata  <= 32'd0;
      r_hwdata <= 32'd0;
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
      r_berr   <= 1'b0;
      r_aerr   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= (r_state == S_DATA) && ahb_hready_in && !ahb_hresp_in && !r_hwrite;
      r_berr   <= ((r_state == S_ERR) || ((r_state == S_DATA) && ahb_hresp_in)) && ahb_hready_in;
      r_aerr   <= w_idle && (w_st_bad || w_ld_bad);
      if (w_idle && w_st_go) begin
        r_haddr  <= {dmaddr_in[ADDR_W-1:2], w_st_off};
        r_hsize  <= w_st_hsize;
        r_hwrite <= 1'b1;
        r_wdata  <= dmdata_in;
      end else if (w_idle && w_ld_go) begin
        r_haddr  <= dmrd_addr_in;
        r_hsize  <= {1'b0, dmrd_size_in};
        r_hwrite <= 1'b0;
      end
      // HWDATA only changes on entry to the data phase so it holds otherwise.
      if ((r_state == S_ADDR) && ahb_hready_in && r_hwrite)
        r_hwdata <= r_wdata;
      if ((r_state == S_DATA) && ahb_hready_in && !ahb_hresp_in && !r_hwrite)
        r_rdata <= ahb_hrdata_in;
    end
  end

  assign ahb_haddr_out     = r_haddr;
  assign ahb_htrans_out    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign ahb_hwrite_out    = r_hwrite;
  assign ahb_hsize_out     = r_hsize;
  assign ahb_hwdata_out    = r_hwdata;
  assign ahb_ready_out     = w_idle;
  assign dmrdata_out       = r_rdata;
  assign dmrdata_valid_out = r_rvalid;
  assign bus_err_out       = r_berr;
  assign align_err_out     = r_aerr;
  assign dbg_state_out     = r_state;

endmodule
